tt_sweeper: RTL

TT_SWEEPER -- requirements
Module: tt_sweeper

---
 rtl/tt_sweeper_pkg.sv | 15 +
 rtl/tt_sweeper_if.sv | 27 ++
 rtl/tt_sweeper_pattern_ctr.sv | 66 ++++++
 rtl/tt_sweeper.sv | 117 +++++++++++
 4 files changed

// File: rtl/tt_sweeper_pkg.sv
// Shared types and widths for the truth-table sweeper: FSM state encoding,
// stimulus pattern width and captured table width.
package tt_sweep_pkg;

  localparam int PATTERN_W = 3;
  localparam int TABLE_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

endpackage

// File: rtl/tt_sweeper_if.sv
// Bundle of the sweeper's control, stimulus and result signals. The slave
// modport is the sweeper; the master modport is the block driving it.
interface tt_sweeper_if;

  logic                             start;
  logic                             first_in;
  logic                             second_in;
  logic                             third_in;
  logic                             the_output;
  logic                             busy;
  logic                             done;
  logic [tt_sweep_pkg::TABLE_W-1:0] tt_result;
  logic                             unstable;
  logic [tt_sweep_pkg::TABLE_W-1:0] expected;
  logic                             mismatch;

  modport slave (
    input  start, the_output, expected,
    output first_in, second_in, third_in, busy, done, tt_result, unstable, mismatch
  );

  modport master (
    output start, the_output, expected,
    input  first_in, second_in, third_in, busy, done, tt_result, unstable, mismatch
  );

endinterface

// File: rtl/tt_sweeper_pattern_ctr.sv
// Pattern index, settle and pass counters for tt_sweeper, with wrap flags
// that mark the last settle cycle, the last pattern and the last pass.
module tt_pattern_ctr
  import tt_sweep_pkg::*;
#(
  parameter int PASSES        = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 settle_inc_i,
  input  logic                 idx_inc_i,
  output logic [PATTERN_W-1:0] idx_o,
  output logic [3:0]           pass_o,
  output logic                 settle_wrap_o,
  output logic                 idx_wrap_o,
  output logic                 pass_wrap_o
);

  // With SETTLE_CYCLES=0 the settle counter is never stepped, so its last value is moot.
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

  logic [3:0]           settle_q, settle_d;
  logic [PATTERN_W-1:0] idx_q, idx_d;
  logic [3:0]           pass_q, pass_d;

  assign settle_wrap_o = (settle_q == SETTLE_LAST);
  assign idx_wrap_o    = (idx_q == '1);
  assign pass_wrap_o   = (pass_q == PASS_LAST);
  assign idx_o         = idx_q;
  assign pass_o        = pass_q;

  // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    settle_d = settle_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
    if (clr_i) begin
      settle_d = '0;
      idx_d    = '0;
      pass_d   = '0;
    end else begin
      if (settle_inc_i) settle_d = settle_wrap_o ? 4'd0 : settle_q + 4'd1;
      if (idx_inc_i) begin
        idx_d = idx_q + 1'b1;
        if (idx_wrap_o) pass_d = pass_wrap_o ? 4'd0 : pass_q + 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
      idx_q    <= '0;
      pass_q   <= '0;
    end else begin
      settle_q <= settle_d;
      idx_q    <= idx_d;
      pass_q   <= pass_d;
    end
  end

endmodule

// File: rtl/tt_sweeper.sv
// Truth-table sweeper: drives all 3-bit patterns PASSES times, captures the
// response table and flags instability. Optional TT_SWEEP_COMPARE_EN adds a
// registered comparison of the final table against 'expected'.
module tt_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int PASSES        = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tt_sweeper_if.slave  bus
);

  state_e               state_q, state_d;
  logic                 clr, settle_inc, idx_inc, capture;
  logic [PATTERN_W-1:0] idx;
  logic [3:0]           pass;
  logic                 settle_wrap, idx_wrap, pass_wrap;
  logic [TABLE_W-1:0]   tt_result_q, tt_result_d;
  logic                 unstable_q, unstable_d;
  state_e               after_pattern;

  tt_pattern_ctr #(
    .PASSES        (PASSES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_ctr (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (clr),
    .settle_inc_i  (settle_inc),
    .idx_inc_i     (idx_inc),
    .idx_o         (idx),
    .pass_o        (pass),
    .settle_wrap_o (settle_wrap),
    .idx_wrap_o    (idx_wrap),
    .pass_wrap_o   (pass_wrap)
  );

  // A zero settle time skips DRIVE entirely and samples every cycle.
  assign after_pattern = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;

  always_comb begin
    state_d    = state_q;
    clr        = 1'b0;
    settle_inc = 1'b0;
    idx_inc    = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        clr     = 1'b1;
        state_d = after_pattern;
      end
      DRIVE: begin
        settle_inc = 1'b1;
        if (settle_wrap) state_d = SAMPLE;
      end
      SAMPLE: begin
        capture = 1'b1;
        idx_inc = 1'b1;
        state_d = (idx_wrap && pass_wrap) ? DONE : after_pattern;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tt_result_d = tt_result_q;
    unstable_d  = unstable_q;
    if (clr) begin
      tt_result_d = '0;
      unstable_d  = 1'b0;
    end else if (capture) begin
      tt_result_d[idx] = bus.the_output;
      if (pass != 4'd0 && bus.the_output != tt_result_q[idx]) unstable_d = 1'b1;
    end
  end

  // NOTE: asynchronous reset clears every register here, including the captured table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tt_result_q <= '0;
      unstable_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tt_result_q <= tt_result_d;
      unstable_q  <= unstable_d;
    end
  end

  assign {bus.first_in, bus.second_in, bus.third_in} =
    (state_q == DRIVE || state_q == SAMPLE) ? idx : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.tt_result = tt_result_q;
  assign bus.unstable  = unstable_q;

`ifdef TT_SWEEP_COMPARE_EN
  logic mismatch_q;

  // In DONE the table already holds the final sample, so compare it there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                mismatch_q <= 1'b0;
    else if (clr)              mismatch_q <= 1'b0;
    else if (state_q == DONE)  mismatch_q <= (tt_result_q != bus.expected);
  end

  assign bus.mismatch = mismatch_q;
`else
  logic unused_expected;
  assign unused_expected = ^bus.expected;
  assign bus.mismatch    = 1'b0;
`endif

endmodule
